// File: rtl/pakin_io_if.sv
// Bus bundle for the pakin_io packet sink: the upstream 4-phase req/ack
// channel, the downstream valid/ready head port, and the status outputs.
// The DUT connects through the slave modport; a driver/monitor uses master.

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

interface pakin_io_if #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE
);
    // Upstream 4-phase channel
    logic [ASZ-1:0] i0_src;
    logic [ASZ-1:0] i0_dst;
    logic [DSZ-1:0] i0_dat;
    logic [RSZ-1:0] i0_red;
    logic           i0_req;
    logic           i0_ack;

    // Downstream head-of-FIFO port
    logic [ASZ-1:0] o_src;
    logic [ASZ-1:0] o_dst;
    logic [DSZ-1:0] o_dat;
    logic [RSZ-1:0] o_red;
    logic           o_vld;
    logic           i_rdy;

    // Status
    logic [15:0]    o_pkt_cnt;
    logic           o_err_addr;
    logic           o_err_red;
    logic           o_err_seq;
    logic           dbg_busy;

    modport slave (
        input  i0_src, i0_dst, i0_dat, i0_red, i0_req, i_rdy,
        output i0_ack, o_src, o_dst, o_dat, o_red, o_vld,
               o_pkt_cnt, o_err_addr, o_err_red, o_err_seq, dbg_busy
    );

    modport master (
        output i0_src, i0_dst, i0_dat, i0_red, i0_req, i_rdy,
        input  i0_ack, o_src, o_dst, o_dat, o_red, o_vld,
               o_pkt_cnt, o_err_addr, o_err_red, o_err_seq, dbg_busy
    );
endinterface

// File: rtl/pakin_io.sv
// pakin_io: packet sink for one 4-phase req/ack channel. Each handshake
// captures one packet, checks destination range, redundancy and sequence
// number, buffers in-range packets in a small FIFO and presents the FIFO
// head on a valid/ready port. Error flags are sticky until reset.

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module pakin_io #(
    parameter int MIN_ADDR = 1,
    parameter int MAX_ADDR = 1,
    parameter int ASZ      = `NS_ADDRESS_SIZE,
    parameter int DSZ      = `NS_DATA_SIZE,
    parameter int RSZ      = `NS_REDUN_SIZE,
    parameter int DEPTH    = 4,
    parameter int INIT_SEQ = 5,
    parameter int EXP_RED  = 15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    pakin_io_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACKED = 1'b1
    } state_t;

    typedef struct packed {
        logic [ASZ-1:0] src;
        logic [ASZ-1:0] dst;
        logic [DSZ-1:0] dat;
        logic [RSZ-1:0] red;
    } pkt_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_capture;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_addr_ok;
    logic            w_red_ok;
    logic            w_seq_ok;
    pkt_t            w_in;
    pkt_t            w_head;

    pkt_t            r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [3:0]      r_exp_seq;
    logic [15:0]     r_pkt_cnt;
    logic            r_err_addr;
    logic            r_err_red;
    logic            r_err_seq;

    // Full is judged on the count before any same-edge pop, so a pop never
    // opens room for a capture at the same edge.
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = bus.o_vld && bus.i_rdy;
    assign w_addr_ok = (bus.i0_dst >= ASZ'(MIN_ADDR)) && (bus.i0_dst <= ASZ'(MAX_ADDR));
    assign w_red_ok  = (bus.i0_red == RSZ'(EXP_RED));
    assign w_seq_ok  = (bus.i0_dat[3:0] == r_exp_seq);
    assign w_push    = w_capture && w_addr_ok;
    assign w_in      = {bus.i0_src, bus.i0_dst, bus.i0_dat, bus.i0_red};

    // Handshake state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake next-state and capture decode
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned,
        // which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.i0_req && !w_full) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ACKED;
                end
            end
            ST_ACKED: begin
                if (!bus.i0_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // FIFO storage write
    always_ff @(posedge i_clk) begin
        // NOTE: the storage array has no reset; validity is tracked by the
        // pointers and count, so stale contents are never presented.
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Field checks, sequence tracking and packet counter on each capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exp_seq  <= 4'(INIT_SEQ);
            r_pkt_cnt  <= '0;
            r_err_addr <= 1'b0;
            r_err_red  <= 1'b0;
            r_err_seq  <= 1'b0;
        end else if (w_capture) begin
            // Sequence resyncs to the received value even after a mismatch,
            // so one bad packet raises the flag once rather than forever.
            r_exp_seq <= bus.i0_dat[3:0] + 4'd1;
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
            if (!w_addr_ok) begin
                r_err_addr <= 1'b1;
            end
            if (!w_red_ok) begin
                r_err_red <= 1'b1;
            end
            if (!w_seq_ok) begin
                r_err_seq <= 1'b1;
            end
        end
    end

    assign w_head         = r_mem[r_rd_ptr];

    assign bus.i0_ack     = (r_state == ST_ACKED);
    assign bus.o_vld      = (r_count != '0);
    assign bus.o_src      = w_head.src;
    assign bus.o_dst      = w_head.dst;
    assign bus.o_dat      = w_head.dat;
    assign bus.o_red      = w_head.red;
    assign bus.o_pkt_cnt  = r_pkt_cnt;
    assign bus.o_err_addr = r_err_addr;
    assign bus.o_err_red  = r_err_red;
    assign bus.o_err_seq  = r_err_seq;
    assign bus.dbg_busy   = bus.i0_ack | bus.o_vld;

endmodule
